// File: rtl/zed64_vid_pkg.sv
// Purpose: shared constants for the video mode controller: modeline packing, register map, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zed64_vid_pkg;

    // Modeline field width and total packed width
    localparam int MLW         = 12;
    localparam int ML_PACKED_W = 98;

    // LSB positions of each field in {hdisp,hstart,hend,htotal,hsi,vdisp,vstart,vend,vtotal,vsi}
    localparam int ML_HDISP_LSB  = 86;
    localparam int ML_HSTART_LSB = 74;
    localparam int ML_HEND_LSB   = 62;
    localparam int ML_HTOTAL_LSB = 50;
    localparam int ML_HSI_BIT    = 49;
    localparam int ML_VDISP_LSB  = 37;
    localparam int ML_VSTART_LSB = 25;
    localparam int ML_VEND_LSB   = 13;
    localparam int ML_VTOTAL_LSB = 1;
    localparam int ML_VSI_BIT    = 0;

    // Register offsets within the 16-byte window
    localparam logic [3:0] REG_MODE   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h1;

    // Mode-change sequencer states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HOLD    = 3'd1,
        SETTLE0 = 3'd2,
        SETTLE1 = 3'd3,
        LOAD    = 3'd4,
        REL     = 3'd5
    } vm_state_t;

endpackage

// File: rtl/vidmode_ctrl_debounce.sv
// Purpose: synchronise and debounce a raw pushbutton, emit a 1-cycle pulse on each accepted press.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 cycle to the pulse.
// Backpressure: none; the pulse is fire-and-forget.
// Ports: cpu_clk/act_reset (async, active-high), but_in (raw async button), btn_req (press pulse).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic cpu_clk,
    input  logic act_reset,
    input  logic but_in,
    output logic btn_req
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_ff;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge cpu_clk or posedge act_reset) begin
        if (act_reset) begin
            sync_ff  <= 2'b00;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_ff  <= {sync_ff[0], but_in};
            stable_d <= stable;
            // Counter measures how long the synchronised input has disagreed with
            // the accepted level; any return to the accepted level restarts it.
            if (sync_ff[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_ff[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Both terms are registers, so the pulse is glitch-free.
    assign btn_req = stable & ~stable_d;

endmodule

// File: rtl/vidmode_ctrl.sv
// Purpose: CPU-domain video mode controller: button + MODE/STATUS registers drive a glitch-free mode-change sequence.
// Latency: request at edge t -> mode_idx/vid_hold at t, ml_out at t+HOLD_CYCLES+3, vid_hold low at t+HOLD_CYCLES+4.
// Backpressure: requests during a sequence are held one deep (last wins) and serviced from IDLE.
// Ports: cpu_clk/act_reset, but_center, cpu_addr/cpu_dataw/cpu_wr -> reg_hit/reg_rdata,
//        mode_idx -> ROMs, ml_in from ROMs, ml_out/vid_hold -> vidcon, busy.
module vidmode_ctrl
    import zed64_vid_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter int          HOLD_CYCLES     = 64,
    parameter logic [15:0] REG_BASE        = 16'h6F00
) (
    input  logic                   cpu_clk,
    input  logic                   act_reset,
    input  logic                   but_center,
    input  logic [15:0]            cpu_addr,
    input  logic [7:0]             cpu_dataw,
    input  logic                   cpu_wr,
    output logic                   reg_hit,
    output logic [7:0]             reg_rdata,
    output logic [1:0]             mode_idx,
    input  logic [ML_PACKED_W-1:0] ml_in,
    output logic [ML_PACKED_W-1:0] ml_out,
    output logic                   vid_hold,
    output logic                   busy
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    vm_state_t      state;
    logic [HCW-1:0] cnt;
    logic           pending;
    logic [1:0]     tgt;

    logic           btn_req;
    logic [3:0]     reg_off;
    logic           mode_wr;
    logic           req;
    logic [1:0]     req_tgt;
    logic           unused_dataw;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .cpu_clk  (cpu_clk),
        .act_reset(act_reset),
        .but_in   (but_center),
        .btn_req  (btn_req)
    );

    assign reg_off      = cpu_addr[3:0];
    assign reg_hit      = (cpu_addr[15:4] == REG_BASE[15:4]);
    assign mode_wr      = cpu_wr & reg_hit & (reg_off == REG_MODE);
    assign unused_dataw = ^cpu_dataw[7:2];

    // A CPU write to MODE overrides a button press landing in the same cycle.
    assign req     = mode_wr | btn_req;
    assign req_tgt = mode_wr ? cpu_dataw[1:0] : (mode_idx + 2'd1);

    assign busy = (state != IDLE);

    always_comb begin
        reg_rdata = 8'h00;
        if (reg_hit) begin
            case (reg_off)
                REG_MODE:   reg_rdata = {6'b0, mode_idx};
                REG_STATUS: reg_rdata = {4'b0, mode_idx, pending, busy};
                default:    reg_rdata = 8'h00;
            endcase
        end
    end

    // Reset lands in HOLD with vid_hold high so mode 0 is loaded automatically
    // after release, exactly as for any other mode change.
    always_ff @(posedge cpu_clk or posedge act_reset) begin
        if (act_reset) begin
            state    <= HOLD;
            cnt      <= '0;
            mode_idx <= 2'd0;
            ml_out   <= '0;
            vid_hold <= 1'b1;
            pending  <= 1'b0;
            tgt      <= 2'd0;
        end else begin
            if (state != IDLE && req) begin
                pending <= 1'b1;
                tgt     <= req_tgt;
            end

            case (state)
                IDLE: begin
                    // A fresh request supersedes a stored one (last request wins).
                    if (req || pending) begin
                        mode_idx <= req ? req_tgt : tgt;
                        vid_hold <= 1'b1;
                        cnt      <= '0;
                        pending  <= 1'b0;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == HCW'(HOLD_CYCLES - 1)) begin
                        state <= SETTLE0;
                    end else begin
                        cnt <= cnt + HCW'(1);
                    end
                end
                // Two cycles for the ROM output to follow the new mode_idx.
                SETTLE0: state <= SETTLE1;
                SETTLE1: state <= LOAD;
                LOAD: begin
                    ml_out <= ml_in;
                    state  <= REL;
                end
                REL: begin
                    vid_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vidmode_ctrl.sv
// Purpose: directed self-checking bench for vidmode_ctrl (DEBOUNCE_CYCLES=8, HOLD_CYCLES=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_vidmode_ctrl;

    logic        cpu_clk;
    logic        act_reset;
    logic        but_center;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dataw;
    logic        cpu_wr;
    logic        reg_hit;
    logic [7:0]  reg_rdata;
    logic [1:0]  mode_idx;
    logic [97:0] ml_in;
    logic [97:0] ml_out;
    logic        vid_hold;
    logic        busy;

    int ncmp  = 0;
    int nfail = 0;

    vidmode_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (4),
        .REG_BASE       (16'h6F00)
    ) dut (
        .cpu_clk   (cpu_clk),
        .act_reset (act_reset),
        .but_center(but_center),
        .cpu_addr  (cpu_addr),
        .cpu_dataw (cpu_dataw),
        .cpu_wr    (cpu_wr),
        .reg_hit   (reg_hit),
        .reg_rdata (reg_rdata),
        .mode_idx  (mode_idx),
        .ml_in     (ml_in),
        .ml_out    (ml_out),
        .vid_hold  (vid_hold),
        .busy      (busy)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    // ROM model: a distinct modeline per mode index
    function automatic logic [97:0] mlpat(input logic [1:0] m);
        int k;
        k = int'(m);
        return {12'(100 + k), 12'(200 + k), 12'(300 + k), 12'(400 + k), m[0],
                12'(500 + k), 12'(600 + k), 12'(700 + k), 12'(800 + k), m[1]};
    endfunction

    assign ml_in = mlpat(mode_idx);

    task automatic tick;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_dataw = d;
        cpu_wr    = 1'b1;
        tick();
        cpu_wr    = 1'b0;
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        cpu_addr = 16'h6F01;
        #1;
        check(tag, reg_rdata, exp);
    endtask

    // Press (optionally with bounce), hold, release; expect exactly one sequence.
    task automatic press(input bit bounce, input logic [1:0] exp_mode, input string tag);
        int   rises;
        logic prev_busy;
        rises     = 0;
        prev_busy = busy;
        if (bounce) begin
            but_center = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (busy && !prev_busy) rises++;
                prev_busy = busy;
            end
            but_center = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (busy && !prev_busy) rises++;
                prev_busy = busy;
            end
        end
        but_center = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        but_center = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check({tag, "_sequences"}, rises, 1);
        check({tag, "_mode"}, mode_idx, exp_mode);
        check({tag, "_ml_out"}, ml_out, mlpat(exp_mode));
        check({tag, "_hold"}, vid_hold, 1'b0);
    endtask

    initial begin
        int   rises;
        logic prev_busy;
        bit   found;
        bit   saw_mode1;

        act_reset  = 1'b1;
        but_center = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_dataw  = 8'h00;
        cpu_wr     = 1'b0;
        #1;
        check("rst_mode", mode_idx, 2'd0);
        check("rst_hold", vid_hold, 1'b1);
        check("rst_ml_out", ml_out, 98'd0);
        check("rst_busy", busy, 1'b1);
        tick();
        tick();
        act_reset = 1'b0;

        // Auto-load of mode 0 after reset release
        for (int i = 1; i <= 6; i++) tick();
        check("boot_hold_e6", vid_hold, 1'b1);
        check("boot_ml_e6", ml_out, 98'd0);
        tick();
        check("boot_ml_e7", ml_out, mlpat(2'd0));
        check("boot_hold_e7", vid_hold, 1'b1);
        tick();
        check("boot_hold_e8", vid_hold, 1'b0);
        check("boot_mode", mode_idx, 2'd0);
        check("boot_busy", busy, 1'b0);
        read_status("boot_status", 8'h00);
        check("hit_in_window", reg_hit, 1'b1);
        cpu_addr = 16'h6E01;
        #1;
        check("hit_outside", reg_hit, 1'b0);
        check("rdata_outside", reg_rdata, 8'h00);

        // CPU write MODE<=2 (upper bits set, must be ignored)
        cpu_write(16'h6F00, 8'hFE);
        check("wr2_mode", mode_idx, 2'd2);
        check("wr2_busy", busy, 1'b1);
        check("wr2_hold", vid_hold, 1'b1);
        read_status("wr2_status", 8'h09);
        cpu_addr = 16'h6F00;
        #1;
        check("wr2_mode_reg", reg_rdata, 8'h02);
        for (int i = 0; i < 6; i++) tick();
        check("wr2_ml_e6", ml_out, mlpat(2'd0));
        tick();
        check("wr2_ml_e7", ml_out, mlpat(2'd2));
        check("wr2_hold_e7", vid_hold, 1'b1);
        tick();
        check("wr2_hold_e8", vid_hold, 1'b0);
        check("wr2_busy_e8", busy, 1'b0);

        // Writes to STATUS and unmapped offsets do nothing
        cpu_write(16'h6F01, 8'h03);
        cpu_write(16'h6F05, 8'h01);
        check("ro_busy", busy, 1'b0);
        check("ro_mode", mode_idx, 2'd2);
        cpu_addr = 16'h6F05;
        #1;
        check("unmapped_rdata", reg_rdata, 8'h00);

        // Button: bounced press 2->3, then wrap 3->0, then 0->1
        press(1'b1, 2'd3, "btn_bounce");
        press(1'b0, 2'd0, "btn_wrap");
        press(1'b0, 2'd1, "btn_next");

        // Button pulse and CPU write MODE<=0 in the same IDLE cycle
        but_center = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (dut.u_debounce.btn_req) found = 1'b1;
            else tick();
        end
        check("coll_pulse_seen", found, 1'b1);
        cpu_write(16'h6F00, 8'h00);
        check("coll_mode", mode_idx, 2'd0);
        read_status("coll_status", 8'h01);
        rises     = 0;
        prev_busy = busy;
        for (int i = 0; i < 30; i++) begin
            if (i == 10) but_center = 1'b0;
            tick();
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check("coll_no_extra_seq", rises, 0);
        check("coll_mode_end", mode_idx, 2'd0);
        check("coll_ml_end", ml_out, mlpat(2'd0));

        // Pending: MODE<=2, then 1 and 3 during HOLD; 3 wins, 1 is never applied
        saw_mode1 = 1'b0;
        cpu_write(16'h6F00, 8'h02);
        cpu_write(16'h6F00, 8'h01);
        read_status("pend_status1", 8'h0B);
        cpu_write(16'h6F00, 8'h03);
        read_status("pend_status3", 8'h0B);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mode_idx == 2'd1) saw_mode1 = 1'b1;
        end
        check("pend_gap_hold", vid_hold, 1'b0);
        check("pend_gap_mode", mode_idx, 2'd2);
        check("pend_gap_ml", ml_out, mlpat(2'd2));
        read_status("pend_gap_status", 8'h0A);
        tick();
        check("pend_next_mode", mode_idx, 2'd3);
        check("pend_next_hold", vid_hold, 1'b1);
        read_status("pend_next_status", 8'h0D);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mode_idx == 2'd1) saw_mode1 = 1'b1;
        end
        check("pend_end_hold", vid_hold, 1'b0);
        check("pend_end_ml", ml_out, mlpat(2'd3));
        check("pend_never_mode1", saw_mode1, 1'b0);

        // Reset during HOLD of a mode-2 change with a request pending
        cpu_write(16'h6F00, 8'h02);
        cpu_write(16'h6F00, 8'h03);
        read_status("mid_status", 8'h0B);
        act_reset = 1'b1;
        #1;
        check("mid_rst_mode", mode_idx, 2'd0);
        check("mid_rst_hold", vid_hold, 1'b1);
        check("mid_rst_ml", ml_out, 98'd0);
        read_status("mid_rst_status", 8'h01);
        act_reset = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("rerun_ml_e7", ml_out, mlpat(2'd0));
        check("rerun_hold_e7", vid_hold, 1'b1);
        tick();
        check("rerun_hold_e8", vid_hold, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("rerun_idle", busy, 1'b0);
        check("rerun_mode", mode_idx, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
